quad_decoder: RTL

Quadrature decoder that turns two-phase incremental-encoder signals (A/B) into an up/down position count. It consumes the same up/down counting semantics used elsewhere in the counter library: direction=1 means count up, direction=0 means count down. The block sits between asynchronous encoder pins and the position/velocity logic. It synchronizes and debounces both phases, decodes every legal Gray-code edge into one signed step, and flags illegal double transitions.

---
 rtl/quad_pkg.sv | 30 +++
 rtl/quad_input_filter.sv | 49 ++++
 rtl/quad_decoder.sv | 118 +++++++++++
 3 files changed

// File: rtl/quad_pkg.sv
// Shared types and Gray-code helpers for the quadrature decoder.
package quad_pkg;

    typedef enum logic {
        INIT,
        TRACK
    } state_t;

    // Phase pair packed as {A, B}
    typedef logic [1:0] phase_t;

    // Gray codes in counting-up order (A leads B)
    localparam phase_t GRAY_0 = 2'b00;
    localparam phase_t GRAY_1 = 2'b10;
    localparam phase_t GRAY_2 = 2'b11;
    localparam phase_t GRAY_3 = 2'b01;

    // Successor of a phase code when the encoder turns in the up direction
    function automatic phase_t next_up(input phase_t p);
        phase_t n;
        case (p)
            GRAY_0:  n = GRAY_1;
            GRAY_1:  n = GRAY_2;
            GRAY_2:  n = GRAY_3;
            default: n = GRAY_0;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/quad_input_filter.sv
// Synchronizer chain plus persistence filter for one encoder phase.
module quad_input_filter #(
    parameter int SYNC_STAGES = 2,
    parameter int FILTER_LEN  = 3
) (
    input  logic clk,
    input  logic rstn,
    input  logic phase_i,
    output logic level_o
);

    localparam int CW = $clog2(FILTER_LEN + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(FILTER_LEN - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic                   level_q, level_d;
    logic                   sample;

    assign sample  = sync_q[SYNC_STAGES-1];
    assign level_o = level_q;

    // Count consecutive samples that disagree with the accepted level
    always_comb begin
        cnt_d   = '0;
        level_d = level_q;
        if (sample != level_q) begin
            if (cnt_q == CNT_LAST) begin
                level_d = sample;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // Synchronizer shift and filter state registers
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sync_q  <= '0;
            cnt_q   <= '0;
            level_q <= 1'b0;
        end else begin
            sync_q  <= {sync_q[SYNC_STAGES-2:0], phase_i};
            cnt_q   <= cnt_d;
            level_q <= level_d;
        end
    end

endmodule

// File: rtl/quad_decoder.sv
// Quadrature decoder: filtered A/B phases to an up/down position count.
module quad_decoder
    import quad_pkg::*;
#(
    parameter int WIDTH       = 16,
    parameter int SYNC_STAGES = 2,
    parameter int FILTER_LEN  = 3
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             quad_a,
    input  logic             quad_b,
    input  logic             clear,
    input  logic             err_clr,
    output logic [WIDTH-1:0] count_out,
    output logic             dir,
    output logic             step,
    output logic             err
);

    // After reset the filters still hold 0 while the pins may sit elsewhere;
    // INIT keeps re-adopting the filtered pair until the pipeline has
    // flushed, so a steady pin level at release never looks like motion.
    localparam int SETTLE = SYNC_STAGES + FILTER_LEN;
    localparam int SW     = $clog2(SETTLE + 1);
    localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE);

    logic             fa, fb;
    phase_t           cur, prev_q;
    state_t           state_q;
    logic [SW-1:0]    settle_q;
    logic [WIDTH-1:0] count_q;
    logic             dir_q, step_q, err_q;
    logic             mv_up, mv_dn, mv_bad;

    quad_input_filter #(
        .SYNC_STAGES(SYNC_STAGES),
        .FILTER_LEN (FILTER_LEN)
    ) u_filt_a (
        .clk    (clk),
        .rstn   (rstn),
        .phase_i(quad_a),
        .level_o(fa)
    );

    quad_input_filter #(
        .SYNC_STAGES(SYNC_STAGES),
        .FILTER_LEN (FILTER_LEN)
    ) u_filt_b (
        .clk    (clk),
        .rstn   (rstn),
        .phase_i(quad_b),
        .level_o(fb)
    );

    assign count_out = count_q;
    assign dir       = dir_q;
    assign step      = step_q;
    assign err       = err_q;

    // Classify the transition from the previous phase pair to the current one
    always_comb begin
        cur    = {fa, fb};
        mv_up  = (cur == next_up(prev_q));
        mv_dn  = (prev_q == next_up(cur));
        mv_bad = ((cur ^ prev_q) == 2'b11);
    end

    // FSM, previous-phase register, position counter and status flags
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q  <= INIT;
            settle_q <= '0;
            prev_q   <= GRAY_0;
            count_q  <= '0;
            dir_q    <= 1'b1;
            step_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            step_q <= 1'b0;
            prev_q <= cur;
            if (clear) begin
                count_q <= '0;
            end
            if (err_clr) begin
                err_q <= 1'b0;
            end
            case (state_q)
                INIT: begin
                    if (settle_q == SETTLE_LAST) begin
                        state_q <= TRACK;
                    end else begin
                        settle_q <= settle_q + 1'b1;
                    end
                end
                TRACK: begin
                    if (mv_up) begin
                        dir_q <= 1'b1;
                        if (!clear) begin
                            count_q <= count_q + 1'b1;
                            step_q  <= 1'b1;
                        end
                    end else if (mv_dn) begin
                        dir_q <= 1'b0;
                        if (!clear) begin
                            count_q <= count_q - 1'b1;
                            step_q  <= 1'b1;
                        end
                    end else if (mv_bad) begin
                        err_q <= 1'b1;
                    end
                end
                default: state_q <= INIT;
            endcase
        end
    end

endmodule
